uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
Serial-transmit controller that shares one 8N1 UART transmit line between two byte requesters.
- Derives its own bit timing from sys_clk with an internal baud counter. No divided clock is generated; everything runs on sys_clk.
- Arbitrates round-robin between the two requesters, latches the granted byte and sequences the start, data and stop bits.
- Sits between the CPU/debug byte sources and the board's serial TX pin.

Parameters:
- CLK_DIV, 5208, sys_clk cycles per serial bit (50 MHz / 9600 baud). Legal range >= 2.
- DATA_W, 8, data bits per frame. Fixed at 8 for 8N1; kept as a parameter for width declarations only.

Ports:
- sys_clk  input  1  system clock; all logic on its rising edge
- Reset_n  input  1  asynchronous, active-low reset
- req0_valid  input  1  requester 0 has a byte to send
- req0_data  input  8  requester 0 byte
- req0_ready  output  1  requester 0 byte accepted this cycle
- req1_valid  input  1  requester 1 has a byte to send
- req1_data  input  8  requester 1 byte
- req1_ready  output  1  requester 1 byte accepted this cycle
- tx_out  output  1  serial line; idles high
- busy  output  1  frame in progress (state != IDLE)
- grant_id  output  1  requester whose frame is in progress or was most recently sent
- tx_done  output  1  one-cycle pulse at end of frame

Behaviour:
- Reset (Reset_n low, asynchronous):
  - state = IDLE, tx_out = 1, busy = 0, tx_done = 0, grant_id = 0.
  - Baud counter = 0, bit index = 0, shift register = 0.
  - Round-robin pointer favours req0.
- States: IDLE, START, DATA, STOP.
- Baud counter:
  - Width clog2(CLK_DIV). Held at 0 in IDLE.
  - Outside IDLE it counts 0..CLK_DIV-1 and wraps.
  - bit_end is asserted when the count equals CLK_DIV-1.
- IDLE:
  - reqN_ready is combinational from registered state and the valid inputs. It is high only in IDLE and only for the selected requester.
  - Only one valid: that requester is selected.
  - Both valid: select the requester favoured by the pointer.
  - Transfer happens on the edge where valid && ready. On that edge:
    - latch the byte into the shift register;
    - grant_id <= selected requester;
    - pointer <= the other requester;
    - state <= START.
  - At most one ready is high per cycle. Neither is high outside IDLE.
- START: tx_out = 0 for CLK_DIV cycles. On bit_end go to DATA with bit index 0.
- DATA:
  - tx_out = shift register bit[index], LSB first, each bit held for CLK_DIV cycles.
  - On bit_end: index+1, or go to STOP after index 7.
- STOP: tx_out = 1 for CLK_DIV cycles. On bit_end go to IDLE.
- tx_done:
  - Registered; high for exactly the first IDLE cycle after STOP.
  - The frame spans exactly 10*CLK_DIV cycles, from the first START cycle to the last STOP cycle.
- tx_out is registered (glitch-free) and equals 1 in IDLE.
- Back-to-back frames: a handshake may complete in the same cycle tx_done is high. The minimum inter-frame gap is therefore 1 cycle of idle-high line.
- Data stability:
  - reqN_data may change freely after the handshake; the latched copy is used.
  - A requester dropping valid before ready is seen has no effect; no partial grant.
- Pointer update: changes only on a completed handshake. A single requester sending repeatedly is always served. The pointer alternates after each grant.
- Reset asserted mid-frame: frame abandoned immediately, tx_out = 1 asynchronously, all state as at reset. No tx_done pulse.

Test Plan:
1. CLK_DIV=4, req0 sends 0xA5 → req0_ready high 1 cycle. tx_out sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1. busy high 40 cycles, then tx_done 1 cycle, grant_id=0.
2. After reset, req0 and req1 both valid (0x11, 0x22) → req0 served first. req1 accepted in the tx_done cycle; its frame starts with a 1-cycle gap and grant_id=1. With both asserted again, req0 is granted next (pointer alternates).
3. req1 valid continuously with 0x00 then 0xFF, req0 idle → consecutive frames to req1. Data bits are all-0, then all-1 for 8 bits. Stop bit is high in both.
4. Reset_n pulsed low at bit 3 of DATA (CLK_DIV=4) → tx_out goes to 1 without waiting for a clock edge; no tx_done. The next request sends a full, correct frame.
5. req0_data changed during the frame, and req0_valid toggled while busy → transmitted byte equals the value at handshake. No ready is asserted while busy.
6. CLK_DIV=5208 sanity: one 0x55 frame → each bit is exactly 5208 cycles; total busy time is 52080 cycles.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter between two byte sources feeding one 8N1 serial line,
// with bit timing derived from sys_clk by an internal baud counter.
module uart_tx_scheduler #(
   parameter int CLK_DIV = 5208,
   parameter int DATA_W  = 8
) (
   input  logic              sys_clk,
   input  logic              Reset_n,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              tx_out,
   output logic              busy,
   output logic              grant_id,
   output logic              tx_done
);
   localparam int CW = $clog2(CLK_DIV);
   localparam int IW = $clog2(DATA_W);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);
   localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;

   logic [1:0]        state;
   logic [CW-1:0]     cnt;
   logic [IW-1:0]     idx;
   logic [DATA_W-1:0] shreg;
   logic              ptr, sel, take, bit_end;

   // ptr names the requester that wins when both are valid
   always_comb begin
      sel        = (req0_valid && req1_valid) ? ptr : req1_valid;
      req0_ready = (state == IDLE) && req0_valid && !sel;
      req1_ready = (state == IDLE) && req1_valid && sel;
      take       = req0_ready || req1_ready;
      bit_end    = cnt == CNT_LAST;
   end

   assign busy = state != IDLE;

   always_ff @(posedge sys_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state    <= IDLE;
         cnt      <= '0;
         idx      <= '0;
         shreg    <= '0;
         ptr      <= 1'b0;
         grant_id <= 1'b0;
         tx_out   <= 1'b1;
         tx_done  <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         cnt     <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
         case (state)
            IDLE: if (take) begin
               shreg    <= sel ? req1_data : req0_data;
               grant_id <= sel;
               ptr      <= !sel;
               state    <= START;
               tx_out   <= 1'b0;
            end
            START: if (bit_end) begin
               state  <= DATA;
               idx    <= '0;
               tx_out <= shreg[0];
            end
            DATA: if (bit_end) begin
               if (idx == IDX_LAST) begin
                  state  <= STOP;
                  tx_out <= 1'b1;
               end else begin
                  idx    <= idx + 1'b1;
                  tx_out <= shreg[idx + 1'b1];
               end
            end
            default: if (bit_end) begin
               state   <= IDLE;
               tx_done <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed and random traffic against a frame-level model; a line monitor
// decodes every serial frame and checks it against the queue of expected grants.
module tb_uart_tx_scheduler;
   localparam int D  = 4;
   localparam int D2 = 5208;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n = 1'b1, v0 = 1'b0, v1 = 1'b0;
   logic [7:0] d0 = '0, d1 = '0;
   logic       r0, r1, tx, busy, gid, done;

   uart_tx_scheduler #(.CLK_DIV(D), .DATA_W(8)) dut (
      .sys_clk(clk), .Reset_n(rst_n),
      .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
      .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
      .tx_out(tx), .busy(busy), .grant_id(gid), .tx_done(done));

   logic       rst2 = 1'b1, v2 = 1'b0;
   logic [7:0] d2 = '0;
   logic       r2a, r2b, tx2, busy2, gid2, done2;

   uart_tx_scheduler #(.CLK_DIV(D2), .DATA_W(8)) dut2 (
      .sys_clk(clk), .Reset_n(rst2),
      .req0_valid(v2), .req0_data(d2), .req0_ready(r2a),
      .req1_valid(1'b0), .req1_data(8'h00), .req1_ready(r2b),
      .tx_out(tx2), .busy(busy2), .grant_id(gid2), .tx_done(done2));

   int         errors = 0, checks = 0;
   logic [8:0] sb[$];
   int         wait_n = 0, nhs = 0, n1 = 0;
   logic       ptr = 1'b0, gid_e = 1'b0;
   bit         mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One cycle: a frame occupies 10*D cycles after the accepting edge, then the line is idle again
   task automatic step(input logic a0, input logic [7:0] b0, input logic a1, input logic [7:0] b1);
      logic done_e, idle, s, e0, e1;
      @(negedge clk);
      v0 = a0; d0 = b0; v1 = a1; d1 = b1;
      #1;
      done_e = wait_n == 1;
      if (wait_n != 0) wait_n--;
      idle = wait_n == 0;
      s  = (a0 && a1) ? ptr : a1;
      e0 = idle && a0 && !s;
      e1 = idle && a1 && s;
      chk("ready0", r0, e0);
      chk("ready1", r1, e1);
      chk("busy", busy, !idle);
      chk("tx_done", done, done_e);
      chk("grant_id", gid, gid_e);
      if (idle) chk("idle_line", tx, 1);
      if (e0 || e1) begin
         sb.push_back({s, s ? b1 : b0});
         ptr    = !s;
         gid_e  = s;
         wait_n = 10 * D + 1;
         nhs++;
         if (s) n1++;
      end
   endtask

   task automatic drain();
      repeat (10 * D + 3) step(0, 8'h00, 0, 8'h00);
   endtask

   task automatic do_reset(input bit line_low);
      v0 = 0; v1 = 0;
      @(negedge clk);
      if (line_low) chk("line_before_reset", tx, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_line_high", tx, 1);
      chk("async_busy_low", busy, 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      sb.delete();
      wait_n = 0; ptr = 1'b0; gid_e = 1'b0; mon_en = 1'b1;
   endtask

   // Line monitor: samples every cycle of a frame, requires each bit constant for D cycles
   initial forever begin
      logic [9:0] bits;
      logic [8:0] e;
      logic       g;
      bit         bad, ab;
      @(negedge clk);
      if (mon_en && rst_n === 1'b1 && tx === 1'b0) begin
         bits = '0; bits[0] = tx; g = gid; bad = 0; ab = 0;
         for (int i = 1; i < 10 * D; i++) begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
               ab = 1;
               break;
            end
            if (i % D == 0) bits[i / D] = tx;
            else if (tx !== bits[i / D]) bad = 1;
            if (gid !== g) bad = 1;
         end
         if (!ab) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL frame_unexpected: got byte %02h with nothing queued", bits[8:1]);
            end else begin
               e = sb.pop_front();
               chk("frame_byte", bits[8:1], e[7:0]);
               chk("frame_gid", g, e[8]);
               chk("start_stop", {bits[9], bits[0]}, 2'b10);
               chk("bit_hold", bad, 0);
            end
         end
      end
   end

   initial begin
      fork
         begin : main_seq
            int base;
            do_reset(0);
            step(0, 8'h00, 0, 8'h00);
            step(1, 8'hA5, 0, 8'h00);
            drain();
            do_reset(0);
            base = nhs;
            for (int i = 0; i < 300 && nhs < base + 3; i++) step(1, 8'h11, 1, 8'h22);
            chk("both_valid_grants", nhs - base, 3);
            drain();
            base = n1;
            for (int i = 0; i < 300 && n1 < base + 2; i++) step(0, 8'h00, 1, (n1 == base) ? 8'h00 : 8'hFF);
            chk("req1_stream_grants", n1 - base, 2);
            drain();
            step(1, 8'h00, 0, 8'h00);
            repeat (18) step(0, 8'h00, 0, 8'h00);
            do_reset(1);
            step(0, 8'h00, 0, 8'h00);
            step(1, 8'h96, 0, 8'h00);
            drain();
            for (int i = 0; i < 600; i++)
               step($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 2) == 0, 8'($urandom));
            drain();
            chk("scoreboard_empty", sb.size(), 0);
         end
         begin : full_rate
            int n, mism, k;
            logic [7:0] b6;
            logic xe;
            b6 = 8'h55;
            #1 rst2 = 1'b0;
            repeat (2) @(negedge clk);
            rst2 = 1'b1;
            @(negedge clk);
            v2 = 1'b1; d2 = b6;
            #1 chk("t6_ready", r2a, 1);
            @(negedge clk);
            v2 = 1'b0; d2 = 8'hAA;
            n = 0; mism = 0;
            while (busy2 === 1'b1 && n < 60000) begin
               k = n / D2;
               if (k == 0) xe = 1'b0;
               else if (k == 9) xe = 1'b1;
               else xe = b6[k-1];
               if (tx2 !== xe) mism++;
               n++;
               @(negedge clk);
            end
            chk("t6_busy_cycles", n, 10 * D2);
            chk("t6_bit_errors", mism, 0);
            chk("t6_done", done2, 1);
            chk("t6_gid", gid2, 0);
         end
      join
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
